counter_n: RTL and testbench

Parametrised program/event counter: the successor to the fixed 16-bit counter. It adds configurable width, a configurable terminal value (modulo-N counting), a registered wrap pulse, an asynchronous reset and an optional decrement path. It serves as the CPU program counter at its default settings and as a generic modulo counter elsewhere, for example in timers and video scan counters.

---
 rtl/counter_n.sv | 75 +++++++
 tb/tb_counter_n.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/counter_n.sv
// Parametrised modulo-LAST counter with load, clear and a registered wrap pulse.
// Define COUNTER_N_DECREMENT_EN to enable the count-down path and its down-wrap.
module counter_n #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] LAST = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             increment,
    input  logic             decrement,
    output logic [WIDTH-1:0] out,
    output logic             at_last,
    output logic             wrap
);

    logic [WIDTH-1:0] out_p0;
    logic             wrap_p0;

    // A load value beyond the terminal count saturates to LAST.
    function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] v);
        return (v > LAST) ? LAST : v;
    endfunction

    assign at_last = (out == LAST);

`ifndef COUNTER_N_DECREMENT_EN
    logic unused_decrement;
    assign unused_decrement = decrement;
`endif

    always_comb begin
        out_p0  = out;
        wrap_p0 = 1'b0;
        if (clear) begin
            out_p0 = '0;
        end else if (load) begin
            out_p0 = sat_load(in);
`ifdef COUNTER_N_DECREMENT_EN
        end else if (increment && decrement) begin
            out_p0 = out;
`endif
        end else if (increment) begin
            if (at_last) begin
                out_p0  = '0;
                wrap_p0 = 1'b1;
            end else begin
                out_p0 = out + WIDTH'(1);
            end
`ifdef COUNTER_N_DECREMENT_EN
        end else if (decrement) begin
            if (out == '0) begin
                out_p0  = LAST;
                wrap_p0 = 1'b1;
            end else begin
                out_p0 = out - WIDTH'(1);
            end
`endif
        end
    end

    // Stage p0 -> registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out  <= '0;
            wrap <= 1'b0;
        end else begin
            out  <= out_p0;
            wrap <= wrap_p0;
        end
    end

endmodule

// File: tb/tb_counter_n.sv
// Directed self-checking bench for counter_n: default 16-bit, decade (4-bit, LAST=9)
// and 16-bit LAST=1000 instances sharing one clock and reset.
module tb_counter_n;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Instance A: WIDTH=16, LAST default
    logic        a_clear = 0, a_load = 0, a_inc = 0, a_dec = 0;
    logic [15:0] a_in = '0, a_out;
    logic        a_at_last, a_wrap;

    // Instance B: WIDTH=4, LAST=9
    logic        b_clear = 0, b_load = 0, b_inc = 0, b_dec = 0;
    logic [3:0]  b_in = '0, b_out;
    logic        b_at_last, b_wrap;

    // Instance C: WIDTH=16, LAST=1000
    logic        c_clear = 0, c_load = 0, c_inc = 0, c_dec = 0;
    logic [15:0] c_in = '0, c_out;
    logic        c_at_last, c_wrap;

    counter_n u_a (
        .clock(clock), .reset(reset), .clear(a_clear), .load(a_load), .in(a_in),
        .increment(a_inc), .decrement(a_dec), .out(a_out), .at_last(a_at_last), .wrap(a_wrap)
    );

    counter_n #(.WIDTH(4), .LAST(4'd9)) u_b (
        .clock(clock), .reset(reset), .clear(b_clear), .load(b_load), .in(b_in),
        .increment(b_inc), .decrement(b_dec), .out(b_out), .at_last(b_at_last), .wrap(b_wrap)
    );

    counter_n #(.WIDTH(16), .LAST(16'd1000)) u_c (
        .clock(clock), .reset(reset), .clear(c_clear), .load(c_load), .in(c_in),
        .increment(c_inc), .decrement(c_dec), .out(c_out), .at_last(c_at_last), .wrap(c_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic c, input logic l, input logic i, input logic d,
                           input logic [15:0] v);
        @(negedge clock);
        a_clear = c; a_load = l; a_inc = i; a_dec = d; a_in = v;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_b(input logic c, input logic l, input logic i, input logic d,
                           input logic [3:0] v);
        @(negedge clock);
        b_clear = c; b_load = l; b_inc = i; b_dec = d; b_in = v;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_c(input logic c, input logic l, input logic i, input logic d,
                           input logic [15:0] v);
        @(negedge clock);
        c_clear = c; c_load = l; c_inc = i; c_dec = d; c_in = v;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [3:0] exp_b;

        // Reset state
        #12;
        chk("rst_a_out", 32'(a_out), 32'h0);
        chk("rst_a_wrap", 32'(a_wrap), 32'h0);
        chk("rst_a_at_last", 32'(a_at_last), 32'h0);
        chk("rst_b_out", 32'(b_out), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Count A to 5, then assert reset between edges
        for (int k = 0; k < 5; k++) drive_a(0, 0, 1, 0, 16'h0);
        chk("a_count5", 32'(a_out), 32'h5);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_out", 32'(a_out), 32'h0);
        chk("async_rst_wrap", 32'(a_wrap), 32'h0);
        @(posedge clock);
        #1;
        chk("rst_held_out", 32'(a_out), 32'h0);
        chk("rst_held_wrap", 32'(a_wrap), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        a_inc = 1'b0;

        // Decade counter: 12 increments
        for (int k = 1; k <= 12; k++) begin
            drive_b(0, 0, 1, 0, 4'h0);
            exp_b = 4'(k % 10);
            chk($sformatf("dec_out_%0d", k), 32'(b_out), 32'(exp_b));
            chk($sformatf("dec_wrap_%0d", k), 32'(b_wrap), 32'(exp_b == 4'd0));
            chk($sformatf("dec_at_last_%0d", k), 32'(b_at_last), 32'(exp_b == 4'd9));
        end

        // Priority on A
        drive_a(0, 1, 1, 0, 16'h1234);
        chk("load_inc", 32'(a_out), 32'h1234);
        drive_a(1, 1, 1, 0, 16'h1234);
        chk("clear_load_inc", 32'(a_out), 32'h0);
        drive_a(0, 1, 0, 0, 16'h1234);
        chk("load_only", 32'(a_out), 32'h1234);
        drive_a(0, 0, 1, 0, 16'h1234);
        chk("load_then_inc", 32'(a_out), 32'h1235);

        // Saturating load on C, then wrap from LAST
        drive_c(0, 1, 0, 0, 16'hFFFF);
        chk("sat_load_out", 32'(c_out), 32'd1000);
        chk("sat_load_at_last", 32'(c_at_last), 32'h1);
        drive_c(0, 0, 1, 0, 16'h0);
        chk("c_wrap_out", 32'(c_out), 32'h0);
        chk("c_wrap_pulse", 32'(c_wrap), 32'h1);
        drive_c(0, 0, 0, 0, 16'h0);

        // Full-range wrap on A
        drive_a(0, 1, 0, 0, 16'hFFFF);
        chk("full_load", 32'(a_out), 32'hFFFF);
        chk("full_at_last", 32'(a_at_last), 32'h1);
        chk("full_load_wrap", 32'(a_wrap), 32'h0);
        drive_a(0, 0, 1, 0, 16'h0);
        chk("full_wrap_out", 32'(a_out), 32'h0);
        chk("full_wrap_pulse", 32'(a_wrap), 32'h1);
        drive_a(0, 0, 0, 0, 16'h0);
        chk("full_hold_out", 32'(a_out), 32'h0);
        chk("full_hold_wrap", 32'(a_wrap), 32'h0);

`ifdef COUNTER_N_DECREMENT_EN
        // Decrement path on B
        drive_b(0, 1, 0, 0, 4'd1);
        chk("dn_load1", 32'(b_out), 32'd1);
        drive_b(0, 0, 0, 1, 4'd0);
        chk("dn_to0_out", 32'(b_out), 32'd0);
        chk("dn_to0_wrap", 32'(b_wrap), 32'h0);
        drive_b(0, 0, 0, 1, 4'd0);
        chk("dn_wrap_out", 32'(b_out), 32'd9);
        chk("dn_wrap_pulse", 32'(b_wrap), 32'h1);
        drive_b(0, 0, 1, 1, 4'd0);
        chk("incdec_hold_out", 32'(b_out), 32'd9);
        chk("incdec_hold_wrap", 32'(b_wrap), 32'h0);
`else
        // Decrement ignored on B
        drive_b(0, 1, 0, 0, 4'd5);
        chk("nodn_load5", 32'(b_out), 32'd5);
        drive_b(0, 0, 0, 1, 4'd0);
        chk("nodn_hold", 32'(b_out), 32'd5);
        drive_b(0, 0, 1, 1, 4'd0);
        chk("nodn_incdec", 32'(b_out), 32'd6);
        chk("nodn_incdec_wrap", 32'(b_wrap), 32'h0);
`endif
        drive_b(0, 0, 0, 0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
